// File: rtl/trace_dump_unit_pkg.sv
// Shared constants, state encoding and byte helpers for the trace dump unit.
package trace_dump_unit_pkg;

  localparam logic [7:0] TRACE_HDR = 8'hA5;
  localparam logic [7:0] TRACE_TRL = 8'h5A;

  localparam int unsigned CYCLES_BYTES = 4;
  localparam int unsigned ENTRY_BYTES  = 4;

  typedef enum logic [2:0] {
    StCapture = 3'd0,
    StHeader  = 3'd1,
    StCycles  = 3'd2,
    StCount   = 3'd3,
    StData    = 3'd4,
    StTrailer = 3'd5,
    StDone    = 3'd6
  } trace_state_e;

  // Little-endian byte pick out of a 32-bit word.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_ring_buffer.sv
// Ring buffer holding the most recent DEPTH write-back values with a saturating fill count.
module trace_ring_buffer #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] rd_offset_i,
  output logic [31:0]   rdata_o,
  output logic [AW:0]   fill_o
);

  localparam logic [AW:0] FullFill = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   fill_q;
  logic [AW-1:0] oldest;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (we_i) begin
      wr_ptr_q <= wr_ptr_q + AW'(1);
      if (fill_q != FullFill) begin
        fill_q <= fill_q + (AW+1)'(1);
      end
    end
  end

  // Storage is not reset; only entries below fill are ever read out.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // When full, fill's low bits are zero so the oldest entry is the one at wr_ptr.
  assign oldest  = wr_ptr_q - fill_q[AW-1:0];
  assign rdata_o = mem_q[oldest + rd_offset_i];
  assign fill_o  = fill_q;

endmodule

// File: rtl/trace_dump_unit.sv
// Captures pipeline write-backs and cycle count, then streams a framed report on halt.
module trace_dump_unit
  import trace_dump_unit_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          i_result,
  input  logic                 i_reg_write,
  input  logic                 i_halt,
  input  logic                 i_tx_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_cycle_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [1:0] CyclesLast = 2'(CYCLES_BYTES - 1);
  localparam logic [1:0] EntryLast  = 2'(ENTRY_BYTES - 1);

  trace_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [AW:0]          entry_q, entry_d;

  logic [31:0] rd_data;
  logic [AW:0] fill;
  logic [7:0]  count_byte;
  logic        capture_we;
  logic        tx_valid;
  logic [7:0]  tx_data;

  assign capture_we = (state_q == StCapture) && i_reg_write;

  trace_ring_buffer #(
    .DEPTH(DEPTH)
  ) u_ring (
    .clk_i      (clk),
    .rst_ni     (reset),
    .we_i       (capture_we),
    .wdata_i    (i_result),
    .rd_offset_i(entry_q[AW-1:0]),
    .rdata_o    (rd_data),
    .fill_o     (fill)
  );

  always_comb begin
    count_byte         = '0;
    count_byte[AW:0]   = fill;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StCapture;
      cycle_q    <= '0;
      byte_idx_q <= '0;
      entry_q    <= '0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      byte_idx_q <= byte_idx_d;
      entry_q    <= entry_d;
    end
  end

  // Output byte is a pure function of state registers, so it holds while the sink stalls.
  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    byte_idx_d = byte_idx_q;
    entry_d    = entry_q;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    unique case (state_q)
      StCapture: begin
        byte_idx_d = '0;
        entry_d    = '0;
        if (i_halt) begin
          state_d = StHeader;
        end else if (cycle_q != '1) begin
          cycle_d = cycle_q + CNT_WIDTH'(1);
        end
      end
      StHeader: begin
        tx_valid = 1'b1;
        tx_data  = TRACE_HDR;
        if (i_tx_ready) state_d = StCycles;
      end
      StCycles: begin
        tx_valid = 1'b1;
        tx_data  = byte_sel(cycle_q[31:0], byte_idx_q);
        if (i_tx_ready) begin
          if (byte_idx_q == CyclesLast) begin
            byte_idx_d = '0;
            state_d    = StCount;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      StCount: begin
        tx_valid = 1'b1;
        tx_data  = count_byte;
        if (i_tx_ready) begin
          byte_idx_d = '0;
          entry_d    = '0;
          state_d    = (fill == '0) ? StTrailer : StData;
        end
      end
      StData: begin
        tx_valid = 1'b1;
        tx_data  = byte_sel(rd_data, byte_idx_q);
        if (i_tx_ready) begin
          if (byte_idx_q == EntryLast) begin
            byte_idx_d = '0;
            if (entry_q == fill - (AW+1)'(1)) begin
              state_d = StTrailer;
            end else begin
              entry_d = entry_q + (AW+1)'(1);
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      StTrailer: begin
        tx_valid = 1'b1;
        tx_data  = TRACE_TRL;
        if (i_tx_ready) state_d = StDone;
      end
      StDone: begin
      end
      default: state_d = StCapture;
    endcase
  end

  assign o_tx_valid    = tx_valid;
  assign o_tx_data     = tx_data;
  assign o_busy        = tx_valid;
  assign o_done        = (state_q == StDone);
  assign o_cycle_count = cycle_q;

endmodule

// File: tb/tb_trace_dump_unit.sv
// Scoreboard bench for trace_dump_unit: expected frame bytes queued at halt, popped on transfer.
module tb_trace_dump_unit;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] i_result = '0;
  logic        i_reg_write = 1'b0;
  logic        i_halt = 1'b0;
  logic        i_tx_ready = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_cycle_count;

  always #5 clk = ~clk;

  trace_dump_unit #(
    .DEPTH    (DEPTH),
    .CNT_WIDTH(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_result     (i_result),
    .i_reg_write  (i_reg_write),
    .i_halt       (i_halt),
    .i_tx_ready   (i_tx_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_cycle_count(o_cycle_count)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] hist[$];
  logic [31:0] m_cycles = '0;
  bit          halt_seen = 1'b0;
  int          exp_len = 0;
  int          nbytes = 0;
  bit          rand_ready = 1'b0;
  bit          noise = 1'b0;
  bit          stall_prev = 1'b0;
  logic [7:0]  data_prev = '0;
  logic [7:0]  exp_byte;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Byte monitor: pops scoreboard on every accepted byte, checks hold during stalls.
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_valid", 32'(o_tx_valid), 32'd1);
        check_eq("hold_data", 32'(o_tx_data), 32'(data_prev));
      end
      if (o_tx_valid && i_tx_ready) begin
        nbytes++;
        if (exp_q.size() == 0) begin
          check_eq("extra_byte", 32'(o_tx_data), 32'h100);
        end else begin
          exp_byte = exp_q.pop_front();
          check_eq($sformatf("byte%0d", nbytes - 1), 32'(o_tx_data), 32'(exp_byte));
        end
      end
      stall_prev = o_tx_valid && !i_tx_ready;
      data_prev  = o_tx_data;
    end
  end

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) exp_q.push_back(m_cycles[8*i +: 8]);
    exp_q.push_back(8'(hist.size()));
    foreach (hist[k]) begin
      for (int b = 0; b < 4; b++) exp_q.push_back(hist[k][8*b +: 8]);
    end
    exp_q.push_back(8'h5A);
    exp_len = 7 + 4 * hist.size();
  endtask

  task automatic step(input logic halt, input logic we, input logic [31:0] val);
    i_halt      = halt;
    i_reg_write = we;
    i_result    = val;
    if (!halt_seen) begin
      if (we) begin
        hist.push_back(val);
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      if (halt) begin
        halt_seen = 1'b1;
        push_frame();
      end else begin
        m_cycles++;
      end
    end
    @(posedge clk);
    #1;
    i_reg_write = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    i_halt      = 1'b0;
    i_reg_write = 1'b0;
    i_result    = '0;
    exp_q.delete();
    hist.delete();
    m_cycles  = '0;
    halt_seen = 1'b0;
    nbytes    = 0;
    exp_len   = 0;
    #1;
    check_eq("rst_valid", 32'(o_tx_valid), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_data", 32'(o_tx_data), 32'd0);
    check_eq("rst_cycles", o_cycle_count, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_done(input int budget, input bit no_bubble);
    int cyc = 0;
    check_eq("busy_start", 32'(o_busy), 32'd1);
    while (!o_done && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (noise) begin
        i_reg_write = 1'($urandom_range(0, 1));
        i_result    = $urandom;
      end
    end
    check_eq("done", 32'(o_done), 32'd1);
    check_eq("frame_len", 32'(nbytes), 32'(exp_len));
    check_eq("leftover", 32'(exp_q.size()), 32'd0);
    check_eq("busy_end", 32'(o_busy), 32'd0);
    check_eq("valid_end", 32'(o_tx_valid), 32'd0);
    check_eq("cycles", o_cycle_count, m_cycles);
    if (no_bubble) check_eq("no_bubble", 32'(cyc), 32'(exp_len));
  endtask

  task automatic basic_capture();
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, (e == 2 || e == 5 || e == 8),
           (e == 2) ? 32'h11111111 : (e == 5) ? 32'h22222222 : 32'h33333333);
    end
    step(1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    do_reset();

    // Basic capture, back-to-back.
    basic_capture();
    wait_done(200, 1'b1);
    check_eq("basic_len", 32'(nbytes), 32'd19);
    check_eq("basic_cyc", o_cycle_count, 32'd10);

    // Overflow: oldest four writes are lost.
    do_reset();
    for (int v = 1; v <= 20; v++) step(1'b0, 1'b1, 32'(v));
    step(1'b1, 1'b0, 32'h0);
    wait_done(300, 1'b1);
    check_eq("ovf_len", 32'(nbytes), 32'd71);

    // Empty buffer.
    do_reset();
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    wait_done(50, 1'b1);
    check_eq("empty_len", 32'(nbytes), 32'd7);

    // Backpressure.
    do_reset();
    rand_ready = 1'b1;
    basic_capture();
    wait_done(2000, 1'b0);
    check_eq("bp_len", 32'(nbytes), 32'd19);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Halt with coincident write, halt held forever, writes after halt.
    do_reset();
    step(1'b0, 1'b1, 32'h01234567);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hDEADBEEF);
    noise = 1'b1;
    wait_done(200, 1'b1);
    repeat (10) begin
      @(posedge clk);
      #1;
      i_reg_write = 1'($urandom_range(0, 1));
      i_result    = $urandom;
    end
    noise = 1'b0;
    i_reg_write = 1'b0;
    check_eq("edge_done_sticky", 32'(o_done), 32'd1);
    check_eq("edge_one_frame", 32'(nbytes), 32'd15);
    check_eq("edge_cyc_frozen", o_cycle_count, 32'd2);

    // Reset in the middle of DATA.
    do_reset();
    step(1'b0, 1'b1, 32'hA0A0A0A0);
    step(1'b0, 1'b1, 32'hB0B0B0B0);
    step(1'b0, 1'b1, 32'hC0C0C0C0);
    step(1'b1, 1'b0, 32'h0);
    repeat (8) @(posedge clk);
    #2;
    check_eq("mid_busy_before", 32'(o_busy), 32'd1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_eq("mid_valid", 32'(o_tx_valid), 32'd0);
    check_eq("mid_busy", 32'(o_busy), 32'd0);
    check_eq("mid_done", 32'(o_done), 32'd0);
    check_eq("mid_cycles", o_cycle_count, 32'd0);
    do_reset();
    step(1'b0, 1'b1, 32'h12345678);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h9ABCDEF0);
    step(1'b1, 1'b0, 32'h0);
    wait_done(100, 1'b1);
    check_eq("post_len", 32'(nbytes), 32'd15);
    check_eq("post_cyc", o_cycle_count, 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
